// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light safety monitor: lamp encodings,
// fault codes, monitor states and the per-street flag bundle.
package traffic_light_monitor_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_ILLEGAL   = 3'd1,
    FLT_CONFLICT  = 3'd2,
    FLT_SEQUENCE  = 3'd3,
    FLT_YEL_SHORT = 3'd4,
    FLT_OVERTIME  = 3'd5,
    FLT_PRIORITY  = 3'd6
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_MON   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic illegal;
    logic seq;
    logic yshort;
    logic ovt;
    logic pri;
  } street_flags_t;

  function automatic logic lamp_legal(input logic [2:0] l);
    return (l == LAMP_RED) || (l == LAMP_YEL) || (l == LAMP_GRN);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and fault-report bundle between controller side and monitor.
interface traffic_light_monitor_if;
  logic       tick;
  logic       clr_fault;
  logic [2:0] street_a;
  logic       street_a_pri_lamp;
  logic [2:0] street_b;
  logic       street_b_pri_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_street;
  logic       flash_req;

  modport master (
    output tick, clr_fault, street_a, street_a_pri_lamp, street_b, street_b_pri_lamp,
    input  fault, fault_code, fault_street, flash_req
  );

  modport slave (
    input  tick, clr_fault, street_a, street_a_pri_lamp, street_b, street_b_pri_lamp,
    output fault, fault_code, fault_street, flash_req
  );
endinterface

// File: rtl/traffic_light_monitor_street_checker.sv
// Per-street lamp checker: keeps the previous lamp and phase tick counter,
// flags encoding, sequence, yellow-duration, overtime and priority-lamp violations.
module tl_street_checker
  import traffic_light_monitor_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 5,
  parameter int GRN_MAX = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_arm,
  input  logic          i_tick,
  input  logic [2:0]    i_lamp,
  input  logic          i_pri,
  output street_flags_t o_flags
);

  localparam logic [CNT_W-1:0] C_YMIN = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] C_YMAX = CNT_W'(YEL_MAX);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GRN_MAX);

  logic [2:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_chg;
  logic             w_step_ok;

  assign w_chg     = (i_lamp != r_prev);
  assign w_step_ok = (r_prev == LAMP_GRN && i_lamp == LAMP_YEL) ||
                     (r_prev == LAMP_YEL && i_lamp == LAMP_RED) ||
                     (r_prev == LAMP_RED && i_lamp == LAMP_GRN);

  // A tick landing on a lamp change is dropped; arming restarts the phase timer.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_chg || i_arm)             w_cnt_nxt = '0;
    else if (i_tick && r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
  end

  // Overtime looks at the post-tick count so it fires on the offending tick itself.
  always_comb begin
    o_flags.illegal = !lamp_legal(i_lamp);
    o_flags.seq     = lamp_legal(i_lamp) && w_chg && !w_step_ok;
    o_flags.yshort  = (r_prev == LAMP_YEL) && (i_lamp == LAMP_RED) && (r_cnt < C_YMIN);
    o_flags.ovt     = ((i_lamp == LAMP_YEL) && (w_cnt_nxt > C_YMAX)) ||
                      ((i_lamp == LAMP_GRN) && (w_cnt_nxt > C_GMAX));
    o_flags.pri     = i_pri && (i_lamp != LAMP_GRN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= LAMP_RED;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_lamp;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor top: conflict check, fixed-priority fault encoder and the
// latching fault FSM that requests flashing-yellow fallback.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 5,
  parameter int GRN_MAX = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  traffic_light_monitor_if.slave  bus
);

  mon_state_t    r_state;
  logic          r_fault;
  fault_code_t   r_code;
  logic          r_street;
  street_flags_t w_fa, w_fb;
  fault_code_t   w_code;
  logic          w_street;
  logic          w_arm, w_full, w_conflict;

  assign w_arm      = (r_state == ST_ARM);
  assign w_full     = !w_arm;
  assign w_conflict = (bus.street_a != LAMP_RED) && (bus.street_b != LAMP_RED);

  tl_street_checker #(.CNT_W(CNT_W), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MAX(GRN_MAX)) u_chk_a (
    .clk(clk), .rst_n(rst_n), .i_arm(w_arm), .i_tick(bus.tick),
    .i_lamp(bus.street_a), .i_pri(bus.street_a_pri_lamp), .o_flags(w_fa)
  );

  tl_street_checker #(.CNT_W(CNT_W), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MAX(GRN_MAX)) u_chk_b (
    .clk(clk), .rst_n(rst_n), .i_arm(w_arm), .i_tick(bus.tick),
    .i_lamp(bus.street_b), .i_pri(bus.street_b_pri_lamp), .o_flags(w_fb)
  );

  // Lowest code wins; street A beats street B on the same code.
  always_comb begin
    w_code   = FLT_NONE;
    w_street = 1'b0;
    if      (w_fa.illegal)          w_code = FLT_ILLEGAL;
    else if (w_fb.illegal)          begin w_code = FLT_ILLEGAL;   w_street = 1'b1; end
    else if (w_conflict)            w_code = FLT_CONFLICT;
    else if (w_full && w_fa.seq)    w_code = FLT_SEQUENCE;
    else if (w_full && w_fb.seq)    begin w_code = FLT_SEQUENCE;  w_street = 1'b1; end
    else if (w_full && w_fa.yshort) w_code = FLT_YEL_SHORT;
    else if (w_full && w_fb.yshort) begin w_code = FLT_YEL_SHORT; w_street = 1'b1; end
    else if (w_full && w_fa.ovt)    w_code = FLT_OVERTIME;
    else if (w_full && w_fb.ovt)    begin w_code = FLT_OVERTIME;  w_street = 1'b1; end
    else if (w_fa.pri)              w_code = FLT_PRIORITY;
    else if (w_fb.pri)              begin w_code = FLT_PRIORITY;  w_street = 1'b1; end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ARM;
      r_fault  <= 1'b0;
      r_code   <= FLT_NONE;
      r_street <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM, ST_MON: begin
          if (w_code != FLT_NONE) begin
            r_state  <= ST_FAULT;
            r_fault  <= 1'b1;
            r_code   <= w_code;
            r_street <= w_street;
          end else begin
            r_state  <= ST_MON;
          end
        end
        ST_FAULT: begin
          if (bus.clr_fault && w_code == FLT_NONE) begin
            r_state  <= ST_ARM;
            r_fault  <= 1'b0;
            r_code   <= FLT_NONE;
            r_street <= 1'b0;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign bus.fault        = r_fault;
  assign bus.fault_code   = r_code;
  assign bus.fault_street = r_street;
  assign bus.flash_req    = r_fault;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios with literal expectations,
// then randomized lamp traffic checked every cycle against a rule-level model.
module tb_traffic_light_monitor;

  localparam int CNT_W = 8, YEL_MIN = 2, YEL_MAX = 5, GRN_MAX = 60;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if tif();

  traffic_light_monitor #(.CNT_W(CNT_W), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MAX(GRN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(tif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = just armed (only encoding/conflict/priority rules), 1 = monitoring, 2 = faulted
  logic [2:0] m_lamp[2] = '{3'b100, 3'b100};
  logic [2:0] m_cur[2];
  bit         m_pri[2];
  int         m_cnt[2] = '{0, 0};
  int         m_nxt[2];
  int         m_mode = 0;
  bit         m_full;
  bit         m_fault = 0;
  int         m_code = 0, m_street = 0;

  // colour index G=0, Y=1, R=2; a legal step advances the index by one modulo 3
  function automatic int color(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic bit hit(input int c, input int s);
    int cc, pc;
    cc = color(m_cur[s]);
    pc = color(m_lamp[s]);
    case (c)
      1: return cc < 0;
      2: return s == 0 && m_cur[0] != 3'b100 && m_cur[1] != 3'b100;
      3: return m_full && cc >= 0 && m_cur[s] != m_lamp[s] && !(pc >= 0 && cc == (pc + 1) % 3);
      4: return m_full && pc == 1 && cc == 2 && m_cnt[s] < YEL_MIN;
      5: return m_full && ((cc == 1 && m_nxt[s] > YEL_MAX) || (cc == 0 && m_nxt[s] > GRN_MAX));
      6: return m_pri[s] && cc != 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int code, st;
    m_cur[0] = tif.street_a;          m_cur[1] = tif.street_b;
    m_pri[0] = tif.street_a_pri_lamp; m_pri[1] = tif.street_b_pri_lamp;
    m_full = (m_mode != 0);
    for (int s = 0; s < 2; s++) begin
      if (m_cur[s] != m_lamp[s] || m_mode == 0) m_nxt[s] = 0;
      else if (tif.tick)                        m_nxt[s] = (m_cnt[s] + 1 > CMAX) ? CMAX : m_cnt[s] + 1;
      else                                      m_nxt[s] = m_cnt[s];
    end
    code = 0; st = 0;
    for (int c = 1; c <= 6; c++)
      for (int s = 0; s < 2; s++)
        if (code == 0 && hit(c, s)) begin code = c; st = s; end
    if (m_mode == 2) begin
      if (tif.clr_fault && code == 0) begin
        m_mode = 0; m_fault = 0; m_code = 0; m_street = 0;
      end
    end else if (code != 0) begin
      m_mode = 2; m_fault = 1; m_code = code; m_street = st;
    end else begin
      m_mode = 1;
    end
    for (int s = 0; s < 2; s++) begin
      m_lamp[s] = m_cur[s];
      m_cnt[s]  = m_nxt[s];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lamp = '{3'b100, 3'b100};
      m_cnt  = '{0, 0};
      m_mode = 0; m_fault = 0; m_code = 0; m_street = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("mdl_fault",  8'(tif.fault),        8'(m_fault));
    chk("mdl_code",   8'(tif.fault_code),   8'(m_code));
    chk("mdl_street", 8'(tif.fault_street), 8'(m_street));
    chk("mdl_flash",  8'(tif.flash_req),    8'(m_fault));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set(input logic [2:0] a, input logic [2:0] b);
    tif.street_a = a;
    tif.street_b = b;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tif.tick = 1'b0; cyc();
      tif.tick = 1'b1; cyc();
    end
    tif.tick = 1'b0;
  endtask

  task automatic clear_fault(input string nm);
    tif.clr_fault = 1'b1; cyc();
    tif.clr_fault = 1'b0;
    chk(nm, 8'(tif.fault), 8'd0);
    cyc();
  endtask

  task automatic recover(input string nm);
    set(LR, LR); cyc(); cyc();
    clear_fault(nm);
  endtask

  task automatic do_reset(input logic [2:0] a, input logic [2:0] b);
    #2 rst_n = 1'b0;
    set(a, b);
    tif.street_a_pri_lamp = 1'b0; tif.street_b_pri_lamp = 1'b0;
    tif.tick = 1'b0; tif.clr_fault = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] phase_lamp(input int ph, input int s);
    case (ph)
      0: return (s == 0) ? LG : LR;
      1: return (s == 0) ? LY : LR;
      2: return (s == 0) ? LR : LG;
      default: return (s == 0) ? LR : LY;
    endcase
  endfunction

  initial begin
    int ph, el, dur;
    logic [2:0] a, b;
    bit tk;
    tif.tick = 1'b0; tif.clr_fault = 1'b0;
    tif.street_a_pri_lamp = 1'b1; tif.street_b_pri_lamp = 1'b0;
    set(3'b011, 3'b000);
    #1 rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_fault", 8'(tif.fault), 8'd0);
    chk("rst_code",  8'(tif.fault_code), 8'd0);
    chk("rst_flash", 8'(tif.flash_req), 8'd0);
    tif.street_a_pri_lamp = 1'b0;
    set(LG, LR); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_fault", 8'(tif.fault), 8'd0);

    // three full legal cycles
    repeat (3) begin
      ticks(30); set(LY, LR); ticks(3);
      set(LR, LG); ticks(30); set(LR, LY); ticks(3);
      set(LG, LR);
    end
    cyc();
    chk("normal_fault", 8'(tif.fault), 8'd0);
    chk("normal_code",  8'(tif.fault_code), 8'd0);

    // both green for one cycle
    set(LG, LG); cyc();
    set(LG, LR);
    chk("conflict_fault",  8'(tif.fault), 8'd1);
    chk("conflict_code",   8'(tif.fault_code), 8'd2);
    chk("conflict_street", 8'(tif.fault_street), 8'd0);
    chk("conflict_flash",  8'(tif.flash_req), 8'd1);
    cyc();
    clear_fault("conflict_clr");

    // street B yellow for a single tick
    set(LY, LR); ticks(3);
    set(LR, LG); ticks(5);
    set(LR, LY); ticks(1);
    set(LR, LR); cyc();
    chk("yshort_code",   8'(tif.fault_code), 8'd4);
    chk("yshort_street", 8'(tif.fault_street), 8'd1);
    set(3'b011, LR); cyc();
    chk("sticky_code", 8'(tif.fault_code), 8'd4);
    recover("yshort_clr");

    // red straight to yellow, then a dark lamp
    set(LY, LR); cyc();
    chk("seq_code",   8'(tif.fault_code), 8'd3);
    chk("seq_street", 8'(tif.fault_street), 8'd0);
    recover("seq_clr");
    set(3'b000, LR); cyc();
    chk("illegal_code",   8'(tif.fault_code), 8'd1);
    chk("illegal_street", 8'(tif.fault_street), 8'd0);
    recover("illegal_clr");

    // green overtime
    do_reset(LG, LR);
    ticks(60);
    chk("grn60_fault", 8'(tif.fault), 8'd0);
    ticks(1);
    chk("ovt_fault",  8'(tif.fault), 8'd1);
    chk("ovt_code",   8'(tif.fault_code), 8'd5);
    chk("ovt_street", 8'(tif.fault_street), 8'd0);

    // priority lamp on a red street
    do_reset(LG, LR);
    cyc(); cyc();
    tif.street_b_pri_lamp = 1'b1; cyc();
    tif.street_b_pri_lamp = 1'b0;
    chk("pri_code",   8'(tif.fault_code), 8'd6);
    chk("pri_street", 8'(tif.fault_street), 8'd1);

    // randomized traffic with occasional corruption, clears and resets
    do_reset(LG, LR);
    ph = 0; el = 0; dur = 20;
    for (int i = 0; i < 5000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      tif.tick = tk;
      tif.clr_fault = ($urandom_range(0, 7) == 0);
      a = phase_lamp(ph, 0);
      b = phase_lamp(ph, 1);
      if ($urandom_range(0, 59) == 0) a = 3'($urandom);
      if ($urandom_range(0, 59) == 0) b = 3'($urandom);
      set(a, b);
      tif.street_a_pri_lamp = (a == LG) ? 1'($urandom) : ($urandom_range(0, 49) == 0);
      tif.street_b_pri_lamp = (b == LG) ? 1'($urandom) : ($urandom_range(0, 49) == 0);
      cyc();
      if (tk) begin
        el++;
        if (el >= dur) begin
          ph = (ph + 1) % 4;
          el = 0;
          dur = (ph % 2 == 0) ? int'($urandom_range(1, 64)) : int'($urandom_range(0, 6));
        end
      end
      if ($urandom_range(0, 699) == 0) begin
        do_reset(LG, LR);
        ph = 0; el = 0; dur = 20;
      end
    end
    tif.tick = 1'b0; tif.clr_fault = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
